// File: rtl/ps2_keycode_rx_if.sv
// Keycode bus from the PS/2 receiver to the game logic. The receiver drives it through the master
// modport; consumers read it through the slave modport.
interface ps2_keycode_rx_if;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  modport master (output keycode, key_valid, frame_err);
  modport slave  (input  keycode, key_valid, frame_err);
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 scancode receiver: it translates E0/F0-prefixed codes into HID usage codes on the keycode bus.
// Build option PS2_TIMEOUT_EN aborts a stalled frame after TIMEOUT_CYCLES clocks.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            PS2_CLK,
  input  logic            PS2_DAT,
  ps2_keycode_rx_if.master kbd
);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t             state, state_nx;
  logic [1:0][1:0]    sync;       // [1]=clk, [0]=dat
  logic [1:0]         flt;
  logic [1:0][FW-1:0] fcnt;
  logic               flt_clk_q;
  logic               evt, dat, tmo;
  logic [7:0]         shreg, keycode;
  logic [2:0]         bitcnt;
  logic               par, ext, brk, key_valid, frame_err;
  logic               good, hit;
  logic [7:0]         hid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync <= '1;
    end else begin
      sync[1] <= {sync[1][0], PS2_CLK};
      sync[0] <= {sync[0][0], PS2_DAT};
    end
  end

  // The filtered level changes only after FILTER_LEN consecutive samples that disagree with it.
  for (genvar g = 0; g < 2; g++) begin : g_flt
    always_ff @(posedge Clk) begin
      if (Reset) begin
        flt[g]  <= 1'b1;
        fcnt[g] <= '0;
      end else if (sync[g][1] == flt[g]) begin
        fcnt[g] <= '0;
      end else if (fcnt[g] == FW'(FILTER_LEN - 1)) begin
        flt[g]  <= sync[g][1];
        fcnt[g] <= '0;
      end else begin
        fcnt[g] <= fcnt[g] + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) flt_clk_q <= 1'b1;
    else       flt_clk_q <= flt[1];
  end

  assign evt = flt_clk_q & ~flt[1];
  assign dat = flt[0];

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge Clk) begin
    if (Reset || state == IDLE || evt) idle_cnt <= '0;
    else if (idle_cnt != TW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + 1'b1;
  end

  assign tmo = (state != IDLE) && (idle_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (evt) begin
      case (state)
        IDLE:    if (!dat) state_nx = DATA;
        DATA:    if (bitcnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
    if (tmo) state_nx = IDLE;
  end

  // Odd parity is required across the 8 data bits and the parity bit.
  assign good = (^{shreg, par}) & dat;

  always_comb begin
    hit = 1'b1;
    hid = 8'h00;
    case ({ext, shreg})
      {1'b1, 8'h6B}: hid = 8'h50;
      {1'b1, 8'h74}: hid = 8'h4F;
      {1'b1, 8'h75}: hid = 8'h52;
      {1'b1, 8'h72}: hid = 8'h51;
      {1'b0, 8'h29}: hid = 8'h2C;
      {1'b0, 8'h5A}: hid = 8'h28;
      {1'b0, 8'h76}: hid = 8'h29;
      default:       hit = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shreg     <= '0;
      bitcnt    <= '0;
      par       <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      keycode   <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (tmo) begin
        bitcnt    <= '0;
        ext       <= 1'b0;
        brk       <= 1'b0;
        frame_err <= 1'b1;
      end else if (evt) begin
        case (state)
          IDLE:   bitcnt <= '0;
          DATA: begin
            shreg  <= {dat, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          PARITY: par <= dat;
          STOP: begin
            if (!good) begin
              frame_err <= 1'b1;
            end else if (shreg == 8'hE0) begin
              ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
              brk <= 1'b1;
            end else begin
              ext <= 1'b0;
              brk <= 1'b0;
              if (hit && !brk) begin
                keycode   <= hid;
                key_valid <= 1'b1;
              end else if (hit && keycode == hid) begin
                keycode <= 8'h00;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign kbd.keycode   = keycode;
  assign kbd.key_valid = key_valid;
  assign kbd.frame_err = frame_err;
endmodule
